// File: rtl/fifo_drain_fsm_if.sv
// FIFO read-side bundle for fifo_drain_fsm: FIFO status/data in, read request and
// delivered-word outputs out. master = drain controller, slave = FIFO/consumer side.
interface fifo_drain_fsm_if;
    logic [3:0]  fifo_words;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        rd_en;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [15:0] word_count;
    logic [7:0]  err_count;
    logic        mismatch;

    modport master (
        input  fifo_words, fifo_empty, fifo_rdata,
        output rd_en, data_out, data_valid, word_count, err_count, mismatch
    );

    modport slave (
        output fifo_words, fifo_empty, fifo_rdata,
        input  rd_en, data_out, data_valid, word_count, err_count, mismatch
    );
endinterface

// File: rtl/fifo_drain_fsm.sv
// Hysteresis read controller for the shared 8-bit FIFO: drains from HIGH_MARK down to LOW_MARK.
// Define FIFO_DRAIN_CHECK_EN to add the EXPECTED-pattern checker (err_count / mismatch).
module fifo_drain_fsm #(
    parameter int unsigned HIGH_MARK = 5,
    parameter int unsigned LOW_MARK  = 2,
    parameter logic [7:0]  EXPECTED  = 8'hAA
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_drain_fsm_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_FILL = 2'b01,
        DRAIN     = 2'b10
    } state_t;

    localparam logic [3:0] HIGH_W = 4'(HIGH_MARK);
    localparam logic [3:0] LOW_W  = 4'(LOW_MARK);

    state_t state;
    logic   rd_pend;
    logic   above_low;

    assign above_low = bus.fifo_words > LOW_W;

    // NOTE: rd_en is a pure function of state and inputs, so a continuous assign cannot infer a latch.
    // The fifo_empty term keeps reads off an empty FIFO even when words/empty disagree.
    assign bus.rd_en = (state == DRAIN) && above_low && !bus.fifo_empty;

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      state <= WAIT_FILL;
                WAIT_FILL: if (bus.fifo_words >= HIGH_W) state <= DRAIN;
                DRAIN:     if (!above_low) state <= WAIT_FILL;
                default:   state <= IDLE;
            endcase
        end
    end

    // Read data returns one cycle after rd_en; rd_pend marks that cycle for capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend        <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.data_out   <= 8'h00;
            bus.word_count <= 16'h0000;
        end else begin
            rd_pend        <= bus.rd_en;
            bus.data_valid <= rd_pend;
            if (rd_pend) begin
                bus.data_out   <= bus.fifo_rdata;
                bus.word_count <= bus.word_count + 16'd1;
            end
        end
    end

`ifdef FIFO_DRAIN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_count <= 8'h00;
            bus.mismatch  <= 1'b0;
        end else if (rd_pend && (bus.fifo_rdata != EXPECTED)) begin
            bus.mismatch <= 1'b1;
            if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
        end
    end
`else
    logic unused_expected;

    assign unused_expected = ^EXPECTED;
    assign bus.err_count   = 8'h00;
    assign bus.mismatch    = 1'b0;
`endif

endmodule
